// File: rtl/serial_add_sched.sv
// -----------------------------------------------------------------------------
// serial_add_sched
//
// Shares one bit-serial full-adder cell (plus its carry flip-flop) between two
// requesters. A round-robin arbiter picks one pending request while idle and
// captures that requester's operand pair. The pair is then shifted LSB-first
// through the adder over WIDTH cycles. The finished sum is published with a
// one-cycle done pulse that is tagged with the owning requester id.
//
// Parameters
//   WIDTH    operand/result width in bits (2..32)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req0     requester 0 wants an add; held until ack0
//   a0, b0   requester 0 operands; sampled only at the grant edge
//   ack0     one-cycle pulse: requester 0 operands captured
//   req1     requester 1 request (same rules as req0)
//   a1, b1   requester 1 operands
//   ack1     one-cycle pulse: requester 1 operands captured
//   busy     high whenever the block is not idle
//   done     one-cycle pulse: result/cout/done_id hold a new sum
//   done_id  requester that owns the published result
//   result   sum modulo 2^WIDTH (held until the next done)
//   cout     carry out of the most significant bit (held until the next done)
// -----------------------------------------------------------------------------
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,

    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,

    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    // Bit counter must be able to hold the value WIDTH.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Count value seen during the edge that adds the final (MSB) bit.
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    // acc holds operand A. As A shifts out at the LSB, the sum bits shift in at
    // the MSB. After WIDTH shifts the register therefore holds the full sum.
    // The published result still uses its own register so it never shows
    // partial sums.
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] opb_q,     opb_d;
    logic             carry_q,   carry_d;
    logic [CW-1:0]    count_q,   count_d;
    logic             owner_q,   owner_d;
    logic             last_q,    last_d;

    logic             ack0_d;
    logic             ack1_d;
    logic             busy_d;
    logic             done_d;
    logic             done_id_d;
    logic [WIDTH-1:0] result_d;
    logic             cout_d;

    // -------------------------------------------------------------------------
    // Round-robin arbitration: a lone request wins outright. On a tie, the
    // requester that was not served last wins.
    // -------------------------------------------------------------------------
    logic any_req;
    logic winner;

    assign any_req = req0 | req1;
    assign winner  = (req0 & req1) ? ~last_q : req1;

    // -------------------------------------------------------------------------
    // Shared full-adder cell
    // -------------------------------------------------------------------------
    logic sum_bit;
    logic carry_out;

    assign sum_bit   = acc_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_out = (acc_q[0] & opb_q[0]) |
                       (acc_q[0] & carry_q)  |
                       (opb_q[0] & carry_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        carry_d   = carry_q;
        count_d   = count_q;
        owner_d   = owner_q;
        last_d    = last_q;

        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy;
        done_id_d = done_id;
        result_d  = result;
        cout_d    = cout;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_SHIFT;
                    acc_d   = winner ? a1 : a0;
                    opb_d   = winner ? b1 : b0;
                    carry_d = 1'b0;
                    count_d = '0;
                    owner_d = winner;
                    last_d  = winner;
                    ack0_d  = ~winner;
                    ack1_d  = winner;
                    busy_d  = 1'b1;
                end
            end

            ST_SHIFT: begin
                acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                carry_d = carry_out;
                count_d = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    // Publish on this same edge so done lines up with the
                    // first DONE cycle. The final sum bit is still in flight,
                    // so take it directly from the adder.
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    result_d  = {sum_bit, acc_q[WIDTH-1:1]};
                    cout_d    = carry_out;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            owner_q <= 1'b0;
            // Treat requester 1 as served last, so requester 0 wins the
            // first tie.
            last_q  <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            count_q <= count_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ack0    <= ack0_d;
            ack1    <= ack1_d;
            busy    <= busy_d;
            done    <= done_d;
            done_id <= done_id_d;
            result  <= result_d;
            cout    <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sched
//
// Testbench for serial_add_sched at WIDTH=8. Directed scenarios and
// randomized request traffic are compared against a reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_sched;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0  = 1'b0;
    logic         req1  = 1'b0;
    logic [W-1:0] a0    = '0;
    logic [W-1:0] b0    = '0;
    logic [W-1:0] a1    = '0;
    logic [W-1:0] b1    = '0;
    logic         ack0;
    logic         ack1;
    logic         busy;
    logic         done;
    logic         done_id;
    logic         cout;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_sched #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .ack0    (ack0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .ack1    (ack1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result),
        .cout    (cout)
    );

    // -------------------------------------------------------------------------
    // Reference model. It is scheduled in absolute edge numbers: an accepted
    // operation owns the adder from its grant edge g through edge g+W. Its sum
    // appears at g+W, and the next grant can happen no earlier than g+W+2.
    // -------------------------------------------------------------------------
    int           cyc      = 0;
    int           grant_at = -1000;
    int           free_at  = 0;
    logic         m_last   = 1'b1;
    logic         m_id     = 1'b0;
    logic [W:0]   m_sum    = '0;

    logic         e_ack0   = 1'b0;
    logic         e_ack1   = 1'b0;
    logic         e_busy   = 1'b0;
    logic         e_done   = 1'b0;
    logic         e_id     = 1'b0;
    logic         e_cout   = 1'b0;
    logic [W-1:0] e_result = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        grant_at = -1000;
        free_at  = 0;
        m_last   = 1'b1;
        m_id     = 1'b0;
        m_sum    = '0;
        e_ack0   = 1'b0;
        e_ack1   = 1'b0;
        e_busy   = 1'b0;
        e_done   = 1'b0;
        e_id     = 1'b0;
        e_cout   = 1'b0;
        e_result = '0;
    endtask

    // Predict the outputs after the coming rising edge, using the inputs
    // currently applied.
    task automatic predict();
        cyc++;
        e_ack0 = 1'b0;
        e_ack1 = 1'b0;
        e_done = 1'b0;
        if (cyc >= free_at && (req0 || req1)) begin
            m_id     = (req0 && req1) ? ~m_last : req1;
            m_last   = m_id;
            grant_at = cyc;
            free_at  = cyc + W + 2;
            m_sum    = m_id ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            e_ack0   = ~m_id;
            e_ack1   = m_id;
        end
        e_busy = (cyc >= grant_at) && (cyc <= grant_at + W);
        if (cyc == grant_at + W) begin
            e_done   = 1'b1;
            e_id     = m_id;
            e_result = m_sum[W-1:0];
            e_cout   = m_sum[W];
        end
    endtask

    task automatic compare();
        check("outputs{ack0,ack1,busy,done,done_id,cout,result}",
              64'({ack0, ack1, busy, done, done_id, cout, result}),
              64'({e_ack0, e_ack1, e_busy, e_done, e_id, e_cout, e_result}));
        check("ack_exclusive", 64'(ack0 & ack1), 64'(0));
        check("done_with_ack", 64'(done & (ack0 | ack1)), 64'(0));
    endtask

    // Called at a falling edge with the next inputs applied.
    task automatic cycle();
        predict();
        @(negedge clk);
        compare();
    endtask

    function automatic logic hit(input int sel);
        case (sel)
            0:       return ack0;
            1:       return ack1;
            default: return done;
        endcase
    endfunction

    task automatic run_until(input string name, input int sel, input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!hit(sel) && n < budget);
        check(name, 64'(hit(sel)), 64'(1));
    endtask

    // Raise a request, drop it on its ack, then wait for done. lat counts the
    // cycles from the ack cycle to the done cycle.
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        int n;
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        run_until("ack_timeout", id ? 1 : 0, 30, n);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        run_until("done_timeout", 2, 30, lat);
    endtask

    // Called at a falling edge. Asserts reset between edges, checks the
    // asynchronous clear, then releases reset on a later falling edge.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", 64'({ack0, ack1, busy, done, done_id, cout, result}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    int lat;
    int n;
    int q_ids[$];
    int q_cyc[$];
    int q_res[$];
    int cnt_ack0;
    int cnt_done;
    int exp_ids[3] = '{0, 1, 0};
    int exp_res[3] = '{2, 4, 2};

    initial begin
        @(negedge clk);
        check("reset_outputs_initial", 64'({ack0, ack1, busy, done, done_id, cout, result}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // 3 + 5
        do_op(1'b0, 8'd3, 8'd5, lat);
        check("t1_latency", 64'(lat), 64'(8));
        check("t1_result", 64'(result), 64'(8));
        check("t1_cout", 64'(cout), 64'(0));
        check("t1_done_id", 64'(done_id), 64'(0));
        cycle();
        check("t1_busy_after", 64'(busy), 64'(0));
        check("t1_result_hold", 64'(result), 64'(8));

        // Carry out of the MSB, then no-carry full ones.
        do_op(1'b1, 8'hFF, 8'h01, lat);
        check("t2a_done_id", 64'(done_id), 64'(1));
        check("t2a_result", 64'(result), 64'(0));
        check("t2a_cout", 64'(cout), 64'(1));
        cycle();
        do_op(1'b1, 8'hAA, 8'h55, lat);
        check("t2b_result", 64'(result), 64'(8'hFF));
        check("t2b_cout", 64'(cout), 64'(0));

        // Both requesters held through reset release.
        req0 = 1'b1; a0 = 8'd1; b0 = 8'd1;
        req1 = 1'b1; a1 = 8'd2; b1 = 8'd2;
        apply_reset();
        for (int i = 0; i < 60 && q_res.size() < 3; i++) begin
            cycle();
            if (ack0 || ack1) begin
                q_ids.push_back(ack1 ? 1 : 0);
                q_cyc.push_back(i);
            end
            if (done) q_res.push_back(int'(result));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("t3_done_count", 64'(q_res.size()), 64'(3));
        for (int k = 0; k < 3; k++) begin
            check("t3_grant_id", 64'(k < q_ids.size() ? q_ids[k] : -1), 64'(exp_ids[k]));
            check("t3_result", 64'(k < q_res.size() ? q_res[k] : -1), 64'(exp_res[k]));
        end
        check("t3_spacing_01", 64'(q_cyc.size() >= 2 ? q_cyc[1] - q_cyc[0] : -1), 64'(10));
        check("t3_spacing_12", 64'(q_cyc.size() >= 3 ? q_cyc[2] - q_cyc[1] : -1), 64'(10));
        cycle();

        // req1 arrives while a req0 operation is shifting.
        req0 = 1'b1; a0 = 8'h10; b0 = 8'h20;
        run_until("t4_ack0_timeout", 0, 30, n);
        req0 = 1'b0;
        cycle(); cycle(); cycle();
        req1 = 1'b1; a1 = 8'h33; b1 = 8'h44;
        run_until("t4_ack1_timeout", 1, 30, n);
        check("t4_ack1_delay", 64'(n + 3), 64'(10));
        req1 = 1'b0;
        run_until("t4_done_timeout", 2, 30, lat);
        check("t4_result", 64'(result), 64'(8'h77));
        check("t4_done_id", 64'(done_id), 64'(1));
        cycle();

        // Reset while the bit count is 4.
        req0 = 1'b1; a0 = 8'h20; b0 = 8'h30;
        run_until("t5_ack0_timeout", 0, 30, n);
        req0 = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        apply_reset();
        cnt_done = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (done) cnt_done++;
        end
        check("t5_no_done", 64'(cnt_done), 64'(0));
        do_op(1'b0, 8'd7, 8'd9, lat);
        check("t5_result", 64'(result), 64'(16));
        check("t5_cout", 64'(cout), 64'(0));
        cycle();

        // One-cycle req0 while busy must be dropped without ack or done.
        req1 = 1'b1; a1 = 8'd1; b1 = 8'd1;
        run_until("t6_ack1_timeout", 1, 30, n);
        req1 = 1'b0;
        cycle(); cycle();
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
        cycle();
        req0 = 1'b0;
        cnt_ack0 = 0;
        cnt_done = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (ack0) cnt_ack0++;
            if (done) cnt_done++;
        end
        check("t6_no_ack0", 64'(cnt_ack0), 64'(0));
        check("t6_done_count", 64'(cnt_done), 64'(1));
        check("t6_busy_low", 64'(busy), 64'(0));

        // Random traffic with withdrawals and operand churn after ack.
        for (int i = 0; i < 1500; i++) begin
            if (ack0)                                      req0 = 1'b0;
            else if (req0 && $urandom_range(0, 24) == 0)   req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1; a0 = pick(); b0 = pick();
            end
            if (!req0 && $urandom_range(0, 1) == 0) begin a0 = pick(); b0 = pick(); end

            if (ack1)                                      req1 = 1'b0;
            else if (req1 && $urandom_range(0, 24) == 0)   req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1; a1 = pick(); b1 = pick();
            end
            if (!req1 && $urandom_range(0, 1) == 0) begin a1 = pick(); b1 = pick(); end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Shares one bit-serial full-adder datapath between two requesters.
- Datapath: one full-adder cell plus a carry flip-flop.
- Block arbitrates round-robin, accepts one operand pair, shifts it LSB-first through the adder over WIDTH cycles, then returns the sum with a done pulse tagged by requester id.
- Sits between the requester blocks and the shared adder cell; it is the only owner of that cell.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 wants an add; held until ack0.
- a0  in  WIDTH  requester 0 operand A; stable while req0=1.
- b0  in  WIDTH  requester 0 operand B; stable while req0=1.
- ack0  out  1  one-cycle pulse; requester 0 operands captured.
- req1  in  1  requester 1 request, same rules as req0.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- ack1  out  1  one-cycle pulse; requester 1 operands captured.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result/cout/done_id valid.
- done_id  out  1  requester that owns the current result.
- result  out  WIDTH  sum bits.
- cout  out  1  final carry out.

Behaviour:
- Reset:
  - Clock and reset ports are clk (rising edge) and rst_n; rst_n is asynchronous and active-low.
  - Reset puts the FSM in IDLE.
  - All outputs go to 0: ack0, ack1, busy, done, done_id, result, cout.
  - Shift registers, carry and bit counter go to 0.
  - Round-robin pointer last=1, so req0 wins the first tie.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - At a rising edge with any req high, grant per arbitration rules.
  - Capture the granted a/b into shift registers; carry=0, count=0; go to SHIFT.
  - Registered ack for the winner is high for exactly the next cycle; update last to the winner.
  - With no req, stay in IDLE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last wins.
  - Grant decisions are made only in IDLE.
- SHIFT, each edge:
  - sum = a[0]^b[0]^carry; carry = majority(a[0], b[0], carry).
  - Shift a and b right by one.
  - Shift sum into result register at the MSB (result reg shifts right).
  - count++.
- After the WIDTH-th bit edge (count reaches WIDTH), go to DONE.
- DONE:
  - done=1 for one cycle; done_id = winner.
  - result = full sum; cout = final carry.
  - Next edge goes to IDLE.
- Output hold:
  - result, cout and done_id hold until the next DONE; they are not cleared on leaving DONE.
  - The internal working register must not disturb the visible result during SHIFT; use a separate output register.
- Latency and throughput:
  - The ack cycle is the first SHIFT cycle.
  - done goes high WIDTH cycles after the ack cycle.
  - Minimum spacing between accepts is WIDTH+2 cycles.
- Request handling:
  - A req arriving while busy is ignored until IDLE; it is not lost as long as it is held.
  - Requester may drop req before ack (withdrawal); no ack and no result are produced for it.
  - Operands are sampled only at the grant edge; later changes have no effect.
- Reset mid-operation: the operation is aborted immediately, no done is produced, and outputs read 0.
- Width rules:
  - result is the sum mod 2^WIDTH; cout is bit WIDTH of the true sum.
  - Counter is wide enough for WIDTH.
- ack0 and ack1 are never high in the same cycle; done and ack are never high in the same cycle.

Test Plan:
- WIDTH=8, req0 with a0=3, b0=5 -> ack0 pulse; 8 cycles later done=1, done_id=0, result=8, cout=0; busy low next cycle.
- req1 with a1=0xFF, b1=0x01 -> done_id=1, result=0x00, cout=1. Then a1=0xAA, b1=0x55 -> result=0xFF, cout=0.
- req0 and req1 both held from reset (a0=1, b0=1, a1=2, b1=2) -> grant order: 0 then 1 then 0.
  - Results in sequence: 2, 4, 2.
  - Accept edges exactly 10 cycles apart.
- req1 raised during a req0 SHIFT -> req1 granted on the first IDLE edge after DONE; result correct; no lost or duplicated ack.
- rst_n pulsed low mid-SHIFT (count=4) -> all outputs 0 asynchronously; no done.
  - After release, a fresh req0 with 7+9 gives result=16, cout=0.
- req0 asserted for one cycle while busy, then dropped -> no ack0, no done; busy returns low after the current op.
